// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: bus widths, reset level,
// handshake levels and the divider FSM state encoding.
package div_unit_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   localparam logic RstEnable  = 1'b1;
   localparam logic RstDisable = 1'b0;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_step
   import div_unit_pkg::*;
#(
   parameter int DATA_W = RegBus
) (
   input  logic [DATA_W-1:0] rem,
   input  logic              dividend_msb,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] next_rem,
   output logic              quot_bit
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] trial;

   // rem < divisor always holds, so the shifted value is below 2*divisor and the
   // top bit of the DATA_W+1 bit difference is a reliable sign.
   always_comb begin
      shifted  = {rem, dividend_msb};
      trial    = shifted - {1'b0, divisor};
      quot_bit = ~trial[DATA_W];
      next_rem = quot_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: sign-magnitude restoring divider, one quotient bit
// per clock, result held as {remainder, quotient} while start_i stays high.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = RegBus
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int                CntW    = $clog2(DATA_W);
   localparam logic [CntW-1:0]   LastCnt = CntW'(DATA_W - 1);

   div_state_e        state;
   logic [CntW-1:0]   cnt;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] dvd_q;
   logic [DATA_W-1:0] dvs_q;
   logic              neg_dvd_q;
   logic              neg_dvs_q;

   logic [DATA_W-1:0] step_rem;
   logic              step_bit;
   logic [DATA_W-1:0] mag1;
   logic [DATA_W-1:0] mag2;
   logic [DATA_W-1:0] quot_raw;
   logic [DATA_W-1:0] final_quot;
   logic [DATA_W-1:0] final_rem;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
      return ~v + 1'b1;
   endfunction

   div_step #(
      .DATA_W(DATA_W)
   ) u_step (
      .rem         (rem_q),
      .dividend_msb(dvd_q[DATA_W-1]),
      .divisor     (dvs_q),
      .next_rem    (step_rem),
      .quot_bit    (step_bit)
   );

   // dvd_q doubles as the quotient register: dividend bits leave at the top as
   // quotient bits enter at the bottom, so after the last step it holds |q|.
   always_comb begin
      mag1       = (signed_div_i && opdata1_i[DATA_W-1]) ? negate(opdata1_i) : opdata1_i;
      mag2       = (signed_div_i && opdata2_i[DATA_W-1]) ? negate(opdata2_i) : opdata2_i;
      quot_raw   = {dvd_q[DATA_W-2:0], step_bit};
      final_quot = (neg_dvd_q ^ neg_dvs_q) ? negate(quot_raw) : quot_raw;
      final_rem  = neg_dvd_q ? negate(step_rem) : step_rem;
   end

   // Sign flags are only ever set for signed divisions, so the fixup needs no
   // separate signed/unsigned qualifier.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state     <= DivFree;
         cnt       <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         neg_dvd_q <= 1'b0;
         neg_dvs_q <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               result_o <= '0;
               ready_o  <= DivResultNotReady;
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DivByZero;
                  end else begin
                     state     <= DivOn;
                     cnt       <= '0;
                     rem_q     <= '0;
                     dvd_q     <= mag1;
                     dvs_q     <= mag2;
                     neg_dvd_q <= signed_div_i & opdata1_i[DATA_W-1];
                     neg_dvs_q <= signed_div_i & opdata2_i[DATA_W-1];
                  end
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end else begin
                  state    <= DivEnd;
                  result_o <= '0;
                  ready_o  <= DivResultReady;
               end
            end
            DivOn: begin
               if (annul_i || start_i == DivStop) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end else begin
                  rem_q <= step_rem;
                  dvd_q <= quot_raw;
                  cnt   <= cnt + 1'b1;
                  if (cnt == LastCnt) begin
                     state    <= DivEnd;
                     result_o <= {final_rem, final_quot};
                     ready_o  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: begin
               state    <= DivFree;
               result_o <= '0;
               ready_o  <= DivResultNotReady;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes arithmetic reference results,
// a negedge monitor pops and compares them whenever ready_o rises.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int DATA_W = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                signed_div_i;
   logic [DATA_W-1:0]   opdata1_i;
   logic [DATA_W-1:0]   opdata2_i;
   logic                start_i;
   logic                annul_i;
   logic [2*DATA_W-1:0] result_o;
   logic                ready_o;

   typedef struct packed {
      logic [63:0] result;
      int          latency;
      int          start_edge;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   logic prev_rdy = 1'b0;

   div_unit #(.DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .signed_div_i(signed_div_i),
      .opdata1_i   (opdata1_i),
      .opdata2_i   (opdata2_i),
      .start_i     (start_i),
      .annul_i     (annul_i),
      .result_o    (result_o),
      .ready_o     (ready_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Latency counts rising edges from the start-sampling edge inclusive.
   always @(negedge clk) begin
      if (ready_o === 1'b1 && prev_rdy !== 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_ready: got result %h, expected no result", result_o);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("result", result_o, mon_e.result);
            checkOutput("latency", 64'(cycle - mon_e.start_edge + 1), 64'(mon_e.latency));
         end
      end
      prev_rdy = ready_o;
   end

   function automatic exp_t refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, q, r;
      if (b == 0) begin
         e.result  = 64'd0;
         e.latency = 2;
      end else begin
         if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
         end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
         end
         q = sa / sb;
         r = sa % sb;
         e.result  = {r[31:0], q[31:0]};
         e.latency = DATA_W + 1;
      end
      e.start_edge = 0;
      return e;
   endfunction

   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   n;
      e            = refModel(sgn, a, b);
      e.start_edge = cycle + 1;
      exp_q.push_back(e);
      launch(sgn, a, b);
      n = 0;
      while (ready_o !== 1'b1 && n < 100) begin
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      if (ready_o !== 1'b1) begin
         tests++;
         fails++;
         $display("[TB] FAIL ready_timeout: got ready_o=%b after %0d cycles, expected 1", ready_o, n);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("result_held", result_o, e.result);
      start_i = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready_clear", {63'd0, ready_o}, 64'd0);
      checkOutput("result_clear", result_o, 64'd0);
   endtask

   // Abort a division after `at` ON cycles by annul, start drop or reset.
   task automatic applyAbort(input int kind, input int at);
      logic seen;
      launch(1'b0, 32'd12345, 32'd67);
      repeat (at - 1) @(posedge clk);
      #1;
      if (kind == 0) annul_i = 1'b1;
      else if (kind == 1) start_i = 1'b0;
      else begin
         rst     = 1'b1;
         start_i = 1'b0;
      end
      @(posedge clk); #1;
      annul_i = 1'b0;
      start_i = 1'b0;
      rst     = 1'b0;
      seen    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o !== 1'b0 || result_o !== 64'd0) seen = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput(kind == 0 ? "annul_quiet" : (kind == 1 ? "drop_quiet" : "reset_quiet"),
                  {63'd0, seen}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a, b;
      logic        s;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
      checkOutput("reset_result", result_o, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(1'b0, 32'd100, 32'd7);
      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
      applyStimulus(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 32'd123, 32'd0);
      applyAbort(0, 10);
      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001);
      applyAbort(2, 20);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(1'b1, 32'd0, 32'hFFFF_FFFB);
      applyAbort(1, 5);
      applyStimulus(1'b1, 32'hFFFF_FFF0, 32'd0);

      for (int i = 0; i < 20; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom_range(1, 16);
            1:       b = 32'hFFFF_FFFF - $urandom_range(0, 16);
            2:       b = (i % 5 == 0) ? 32'd0 : $urandom;
            default: b = $urandom;
         endcase
         applyStimulus(s, a, b);
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
